// File: rtl/dec_scan_seq.sv
// Scan sequencer: steps a 4-bit decoder code 0..15, holding each for STEP_CYCLES clocks.
// Optional macro DEC_SCAN_LOOP_EN adds a 'loop' input that restarts the scan without leaving RUN.
module dec_scan_seq #(
  parameter int unsigned STEP_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic hold,
`ifdef DEC_SCAN_LOOP_EN
  input  logic loop,
`endif
  output logic e,
  output logic x,
  output logic y,
  output logic z,
  output logic busy,
  output logic done
);

  localparam int unsigned DW = ($clog2(STEP_CYCLES + 1) < 1) ? 1 : $clog2(STEP_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      code_q, code_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            loop_en;

`ifdef DEC_SCAN_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        code_d  = 4'd0;
        dwell_d = '0;
        if (start && !stop) state_d = RUN;
      end
      RUN: begin
        // stop outranks hold; hold freezes both dwell and code
        if (stop) begin
          state_d = IDLE;
          code_d  = 4'd0;
          dwell_d = '0;
        end else if (!hold) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (code_q == 4'hF) begin
              code_d = 4'd0;
              done_d = 1'b1;
              if (!loop_en) state_d = DONE;
            end else begin
              code_d = code_q + 4'd1;
            end
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        code_d  = 4'd0;
        dwell_d = '0;
      end
      default: begin
        state_d = IDLE;
        code_d  = 4'd0;
        dwell_d = '0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 4'd0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {e, x, y, z} = code_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Scoreboard bench for dec_scan_seq: stimulus pushes expected output transitions,
// monitors pop and compare whenever a DUT's {busy,done,code} changes.
module tb_dec_scan_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic st_a = 1'b0, sp_a = 1'b0, hd_a = 1'b0;
  logic st_b = 1'b0, sp_b = 1'b0, hd_b = 1'b0;
  logic ea, xa, ya, za, ba, da;
  logic eb, xb, yb, zb, bb, db;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         t;
    logic [5:0] v;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  ev_t qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DEC_SCAN_LOOP_EN
  logic lp_a = 1'b0, lp_b = 1'b0, lp_c = 1'b1;
  logic st_c = 1'b0, sp_c = 1'b0, hd_c = 1'b0;
  logic ec, xc, yc, zc, bc, dc;
`endif

  dec_scan_seq #(.STEP_CYCLES(10)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .stop(sp_a), .hold(hd_a),
`ifdef DEC_SCAN_LOOP_EN
    .loop(lp_a),
`endif
    .e(ea), .x(xa), .y(ya), .z(za), .busy(ba), .done(da)
  );

  dec_scan_seq #(.STEP_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .stop(sp_b), .hold(hd_b),
`ifdef DEC_SCAN_LOOP_EN
    .loop(lp_b),
`endif
    .e(eb), .x(xb), .y(yb), .z(zb), .busy(bb), .done(db)
  );

`ifdef DEC_SCAN_LOOP_EN
  dec_scan_seq #(.STEP_CYCLES(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .stop(sp_c), .hold(hd_c),
    .loop(lp_c),
    .e(ec), .x(xc), .y(yc), .z(zc), .busy(bc), .done(dc)
  );
`endif

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int id, input int t, input logic b, input logic d, input logic [3:0] c);
    ev_t ev;
    ev.t = t;
    ev.v = {b, d, c};
    case (id)
      0: qa.push_back(ev);
      1: qb.push_back(ev);
      default: qc.push_back(ev);
    endcase
  endtask

  task automatic cmp_ev(input string nm, input ev_t ex, input int t, input logic [5:0] v);
    checks++;
    if (ex.t !== t || ex.v !== v) begin
      errors++;
      $display("FAIL %s: got cycle %0d busy/done/code=%b, expected cycle %0d busy/done/code=%b",
               nm, t, v, ex.t, ex.v);
    end
  endtask

  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_empty(input string nm, input int sz);
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending events, expected 0", nm, sz);
    end
  endtask

  logic [5:0] pa = '0;
  always @(negedge clk) begin
    logic [5:0] o;
    o = {ba, da, ea, xa, ya, za};
    if (o !== pa) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_a_unexpected: got cycle %0d busy/done/code=%b, expected no change", cyc, o);
      end else cmp_ev("u_a_seq", qa.pop_front(), cyc, o);
      pa = o;
    end
  end

  logic [5:0] pb = '0;
  always @(negedge clk) begin
    logic [5:0] o;
    o = {bb, db, eb, xb, yb, zb};
    if (o !== pb) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_b_unexpected: got cycle %0d busy/done/code=%b, expected no change", cyc, o);
      end else cmp_ev("u_b_seq", qb.pop_front(), cyc, o);
      pb = o;
    end
  end

`ifdef DEC_SCAN_LOOP_EN
  logic [5:0] pc = '0;
  always @(negedge clk) begin
    logic [5:0] o;
    o = {bc, dc, ec, xc, yc, zc};
    if (o !== pc) begin
      if (qc.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_c_unexpected: got cycle %0d busy/done/code=%b, expected no change", cyc, o);
      end else cmp_ev("u_c_seq", qc.pop_front(), cyc, o);
      pc = o;
    end
  end
`endif

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state_a", {ba, da, ea, xa, ya, za}, 6'b0);
    chk("reset_state_b", {bb, db, eb, xb, yb, zb}, 6'b0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Full scan, start held 3 edges (extra edges land in RUN and are ignored)
    n = cyc + 1;
    push(0, n, 1, 0, 4'd0);
    for (int c = 1; c < 16; c++) push(0, n + 10 * c, 1, 0, 4'(c));
    push(0, n + 160, 0, 1, 4'd0);
    push(0, n + 161, 0, 0, 4'd0);
    st_a = 1'b1; tick(3); st_a = 1'b0;
    tick(162);

    // start and stop together in IDLE: nothing happens
    st_a = 1'b1; sp_a = 1'b1; tick(4); st_a = 1'b0; sp_a = 1'b0;
    tick(2);

    // Abort during code 5
    n = cyc + 1;
    push(0, n, 1, 0, 4'd0);
    for (int c = 1; c < 6; c++) push(0, n + 10 * c, 1, 0, 4'(c));
    push(0, n + 55, 0, 0, 4'd0);
    st_a = 1'b1; tick(1); st_a = 1'b0;
    tick(54);
    sp_a = 1'b1; tick(1); sp_a = 1'b0;
    tick(20);

    // hold for 7 edges during code 3
    n = cyc + 1;
    push(0, n, 1, 0, 4'd0);
    for (int c = 1; c < 4; c++) push(0, n + 10 * c, 1, 0, 4'(c));
    for (int c = 4; c < 16; c++) push(0, n + 10 * c + 7, 1, 0, 4'(c));
    push(0, n + 167, 0, 1, 4'd0);
    push(0, n + 168, 0, 0, 4'd0);
    st_a = 1'b1; tick(1); st_a = 1'b0;
    tick(30);
    hd_a = 1'b1; tick(7); hd_a = 1'b0;
    tick(140);

    // Asynchronous reset during code 9, then restart from code 0
    n = cyc + 1;
    push(0, n, 1, 0, 4'd0);
    for (int c = 1; c < 10; c++) push(0, n + 10 * c, 1, 0, 4'(c));
    st_a = 1'b1; tick(1); st_a = 1'b0;
    tick(92);
    chk("code9_before_reset", {ba, da, ea, xa, ya, za}, {2'b10, 4'd9});
    rst_n = 1'b0;
    push(0, cyc, 0, 0, 4'd0);
    #1;
    chk("async_reset_a", {ba, da, ea, xa, ya, za}, 6'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    n = cyc + 1;
    push(0, n, 1, 0, 4'd0);
    push(0, n + 10, 1, 0, 4'd1);
    push(0, n + 15, 0, 0, 4'd0);
    st_a = 1'b1; tick(1); st_a = 1'b0;
    tick(14);
    sp_a = 1'b1; tick(1); sp_a = 1'b0;
    tick(3);

    // STEP_CYCLES=1: start+stop stays idle, then one code per edge
    st_b = 1'b1; sp_b = 1'b1; tick(3); st_b = 1'b0; sp_b = 1'b0;
    tick(1);
    n = cyc + 1;
    push(1, n, 1, 0, 4'd0);
    for (int c = 1; c < 16; c++) push(1, n + c, 1, 0, 4'(c));
    push(1, n + 16, 0, 1, 4'd0);
    push(1, n + 17, 0, 0, 4'd0);
    st_b = 1'b1; tick(1); st_b = 1'b0;
    tick(20);

`ifdef DEC_SCAN_LOOP_EN
    // Looping scan with STEP_CYCLES=2, aborted after the second wrap
    n = cyc + 1;
    push(2, n, 1, 0, 4'd0);
    for (int c = 1; c < 16; c++) push(2, n + 2 * c, 1, 0, 4'(c));
    push(2, n + 32, 1, 1, 4'd0);
    push(2, n + 33, 1, 0, 4'd0);
    for (int c = 1; c < 16; c++) push(2, n + 32 + 2 * c, 1, 0, 4'(c));
    push(2, n + 64, 1, 1, 4'd0);
    push(2, n + 65, 1, 0, 4'd0);
    push(2, n + 66, 0, 0, 4'd0);
    st_c = 1'b1; tick(1); st_c = 1'b0;
    tick(65);
    sp_c = 1'b1; tick(1); sp_c = 1'b0;
    tick(3);
`endif

    chk_empty("u_a_pending", qa.size());
    chk_empty("u_b_pending", qb.size());
    chk_empty("u_c_pending", qc.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
